button_irq_ctrl: RTL and testbench
==================================

BUTTON_IRQ_CTRL -- requirements
Module: button_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of button channels, legal range 1..15.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a level change, minimum 1.
REQ-003 SHALL have parameter ID_W, default $clog2(NUM_CH+1): width of irq_id.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port btn  input  NUM_CH: raw asynchronous button levels, bit i is channel i, active-high.
REQ-007 SHALL have port mask  input  NUM_CH: 1 blocks channel i from raising irq_valid; it does not block latching.
REQ-008 SHALL have port irq_ack  input  1: consumer acknowledges the presented interrupt.
REQ-009 SHALL have port ovf_clr  input  1: clears the overflow flags.
REQ-010 SHALL have port irq_valid  output  1: an interrupt is being presented.
REQ-011 SHALL have port irq_id  output  ID_W: presented channel i encoded as i+1; 0 means none.
REQ-012 SHALL have port pending  output  NUM_CH: latched, unserviced rising edges.
REQ-013 SHALL have port overflow  output  NUM_CH: sticky; an edge arrived while that channel was already pending.

Function
REQ-014 SHALL pass each btn bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL keep a per-channel debounced level and counter:
- Counter clears whenever the synchronised value equals the debounced level.
- Counter increments while the two differ.
- The debounced level flips on the edge where the counter reaches DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
REQ-016 SHALL set pending[i] the cycle after a 0->1 transition of channel i's debounced level; a 1->0 transition has no effect.
REQ-017 SHALL make latency from the first edge sampling btn[i]=1 to irq_valid=1 exactly DEBOUNCE_CYCLES+4 cycles, when the channel is unmasked and irq_valid is idle.
REQ-018 SHALL use a two-state FSM:
- IDLE -> PRESENT when any bit of pending & ~mask is set; irq_id is then loaded with the lowest such index plus 1.
- PRESENT -> IDLE on a cycle with irq_ack=1; that cycle clears pending[irq_id-1].
- irq_valid=1 exactly in PRESENT.
REQ-019 SHALL hold irq_id constant throughout PRESENT, even if mask or pending change.
REQ-020 SHALL force irq_valid=0 for at least one cycle between consecutive presentations.
REQ-021 SHALL ignore irq_ack while in IDLE.
REQ-022 SHALL give set priority when a new edge on channel i coincides with the ack clearing pending[i]: pending[i] stays 1 and overflow[i] is not set.
REQ-023 SHALL set overflow[i] when an edge arrives with pending[i]=1 and no coincident ack; pending[i] stays 1.
REQ-024 SHALL clear all overflow bits on ovf_clr=1; a coincident new overflow event wins.
REQ-025 SHALL drive irq_id=0 whenever irq_valid=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear the synchronisers, debounced levels, counters, pending and overflow, and enter IDLE.
REQ-027 SHALL hold irq_valid=0, irq_id=0, pending=0 and overflow=0 during and after reset.
REQ-028 SHALL apply reset mid-presentation immediately: the presented interrupt is discarded, not retained.

Structure
REQ-029 SHALL take from shared package irq_pkg:
- NUM_BUTTONS=8.
- Button index enum LEFT=0, RIGHT, DOWN, UP, SELECT, START, A, B.
- Constant IRQ_NONE=0.
REQ-030 SHALL instantiate sub-module button_debounce (synchroniser, counter, debounced level, rising-edge pulse) once per channel via generate.
REQ-031 SHALL keep the FSM, priority selection, pending and overflow logic in button_irq_ctrl.

Verification
REQ-032 SHALL cover these scenarios with NUM_CH=8 and DEBOUNCE_CYCLES=4:
- Hold btn[LEFT]=1 -> irq_valid=1 with irq_id=1 exactly 8 cycles later; ack -> irq_valid=0 and pending=0 next cycle.
- Pulse btn[DOWN] high for 3 cycles -> no pending, irq_valid stays 0.
- LEFT and DOWN latched together -> irq_id=1 first; ack; bubble cycle; then irq_id=3.
- mask[A]=1, A pressed -> pending[6]=1 and irq_valid=0; clear mask -> irq_valid=1 with irq_id=7 the next cycle.
- Press B, release, press again without ack -> overflow[7]=1; ovf_clr -> overflow=0, pending[7] still 1.
- Assert rst during PRESENT -> irq_valid=0, irq_id=0, pending=0 the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the button interrupt controller: channel names,
// the "no interrupt" id and the presentation FSM state type.
package irq_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int IRQ_NONE    = 0;

  typedef enum logic [2:0] {
    LEFT   = 3'd0,
    RIGHT  = 3'd1,
    DOWN   = 3'd2,
    UP     = 3'd3,
    SELECT = 3'd4,
    START  = 3'd5,
    A      = 3'd6,
    B      = 3'd7
  } btn_idx_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted 0->1 change of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;

  // The level only moves once the count has reached DEBOUNCE_CYCLES and the
  // synchronised input still disagrees, so short glitches never get through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
        r_rise  <= ~r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/button_irq_ctrl.sv
// Debounced button interrupt controller: latches rising edges as pending,
// tracks overflow, and presents the lowest unmasked pending channel until acked.
module button_irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_CH          = NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn,
  input  logic [NUM_CH-1:0] mask,
  input  logic              irq_ack,
  input  logic              ovf_clr,
  output logic              irq_valid,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow
);

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_ack_clr;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_overflow;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_id_next;
  logic [ID_W-1:0]   w_sel;
  irq_state_e        r_state;
  irq_state_e        w_state_next;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .i_btn (btn[gi]),
      .o_rise(w_rise[gi])
    );

    assign w_ack_clr[gi] = (r_state == ST_PRESENT) && irq_ack && (r_id == ID_W'(gi + 1));
  end

  assign w_req = r_pending & ~mask;

  // Lowest index wins: scan downward so the last hit is the smallest channel.
  always_comb begin
    w_sel = ID_W'(IRQ_NONE);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_id_next    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_next = ST_PRESENT;
          w_id_next    = w_sel;
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          w_state_next = ST_IDLE;
          w_id_next    = ID_W'(IRQ_NONE);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_id_next    = ID_W'(IRQ_NONE);
      end
    endcase
  end

  // A new edge beats a coincident ack; an edge on an already pending channel
  // (without that ack) is what counts as overflow, and it beats ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_id       <= ID_W'(IRQ_NONE);
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_state    <= w_state_next;
      r_id       <= w_id_next;
      r_pending  <= w_rise | (r_pending & ~w_ack_clr);
      r_overflow <= (w_rise & r_pending & ~w_ack_clr) | (r_overflow & ~{NUM_CH{ovf_clr}});
    end
  end

  assign irq_valid = (r_state == ST_PRESENT);
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Bench for button_irq_ctrl: directed scenarios plus random stimulus, checked
// against a window-based reference model and a presentation scoreboard.
module tb_button_irq_ctrl;
  import irq_pkg::*;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int IW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn;
  logic [N-1:0]  mask;
  logic          irq_ack;
  logic          ovf_clr;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  always #5 clk = ~clk;

  button_irq_ctrl #(
    .NUM_CH         (N),
    .DEBOUNCE_CYCLES(D),
    .ID_W           (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .mask     (mask),
    .irq_ack  (irq_ack),
    .ovf_clr  (ovf_clr),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .pending  (pending),
    .overflow (overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Reference model state
  logic [N-1:0] hq[$];
  bit           m_present = 1'b0;
  int           m_id      = 0;
  logic [N-1:0] m_pend    = '0;
  logic [N-1:0] m_ovf     = '0;
  logic [N-1:0] m_lvl     = '0;
  logic [N-1:0] m_rise    = '0;
  int           exp_id_q[$];
  int           exp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // hq[j] holds btn as sampled j+1 edges ago; the synchronised value seen at
  // edge k-t is hq[t+1]. A level accepts a change when the last D+1
  // synchronised samples all disagree with it.
  task automatic model_edge();
    logic [N-1:0] clr, new_pend, nlvl, nrise, req;
    bit           stable;
    int           low;
    if (rst) begin
      m_present = 1'b0;
      m_id      = 0;
      m_pend    = '0;
      m_ovf     = '0;
      m_lvl     = '0;
      m_rise    = '0;
      foreach (hq[t]) hq[t] = '0;
      return;
    end
    clr = '0;
    if (m_present && irq_ack) clr[m_id-1] = 1'b1;
    m_ovf    = (m_rise & m_pend & ~clr) | (ovf_clr ? '0 : m_ovf);
    new_pend = m_rise | (m_pend & ~clr);
    if (!m_present) begin
      req = m_pend & ~mask;
      if (req != '0) begin
        low = 0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            low = i;
            break;
          end
        end
        m_present = 1'b1;
        m_id      = low + 1;
        exp_id_q.push_back(m_id);
        exp_cyc_q.push_back(edge_n);
      end
    end else if (irq_ack) begin
      m_present = 1'b0;
      m_id      = 0;
    end
    nlvl  = m_lvl;
    nrise = '0;
    for (int i = 0; i < N; i++) begin
      stable = 1'b1;
      for (int t = 1; t <= D + 1; t++) begin
        if (hq[t][i] == m_lvl[i]) stable = 1'b0;
      end
      if (stable) begin
        nlvl[i]  = ~m_lvl[i];
        nrise[i] = ~m_lvl[i];
      end
    end
    m_rise = nrise;
    m_lvl  = nlvl;
    m_pend = new_pend;
    hq.push_front(btn);
    void'(hq.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (irq_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Monitor: per-cycle model comparison plus scoreboard pop on each new presentation.
  initial begin
    logic prev_v;
    int   e_id, e_cyc;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      chk("valid", {31'b0, irq_valid}, {31'b0, m_present});
      chk("id", 32'(irq_id), m_id);
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (irq_valid === 1'b1 && prev_v !== 1'b1) begin
        if (exp_id_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got presentation id %0d expected none at edge %0d", irq_id, edge_n);
        end else begin
          e_id  = exp_id_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          chk("sb_id", 32'(irq_id), e_id);
          chk("sb_cycle", edge_n, e_cyc);
        end
      end
      prev_v = irq_valid;
    end
  end

  initial begin
    int n;
    rst     = 1'b1;
    btn     = '0;
    mask    = '0;
    irq_ack = 1'b0;
    ovf_clr = 1'b0;
    for (int t = 0; t < D + 2; t++) hq.push_back('0);

    settle(3);
    chk("rst_valid", {31'b0, irq_valid}, 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    settle(2);

    // LEFT held: fixed latency, then ack
    btn[LEFT] = 1'b1;
    wait_valid(30, n);
    chk("s1_latency", n - 1, D + 4);
    chk("s1_id", 32'(irq_id), 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("s1_ack_valid", {31'b0, irq_valid}, 0);
    chk("s1_ack_pending", 32'(pending), 0);
    btn[LEFT] = 1'b0;
    settle(12);

    // DOWN glitch of 3 cycles is filtered
    btn[DOWN] = 1'b1;
    settle(3);
    btn[DOWN] = 1'b0;
    settle(12);
    chk("s2_pending", 32'(pending), 0);
    chk("s2_valid", {31'b0, irq_valid}, 0);

    // LEFT and DOWN together: priority, bubble, then DOWN
    btn[LEFT] = 1'b1;
    btn[DOWN] = 1'b1;
    wait_valid(30, n);
    chk("s3_first_id", 32'(irq_id), 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("s3_bubble", {31'b0, irq_valid}, 0);
    step();
    chk("s3_second_valid", {31'b0, irq_valid}, 1);
    chk("s3_second_id", 32'(irq_id), 3);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    btn = '0;
    settle(12);

    // Masked A latches but is not presented until unmasked
    mask[A] = 1'b1;
    btn[A]  = 1'b1;
    settle(14);
    chk("s4_pending", 32'(pending), 32'h40);
    chk("s4_valid_masked", {31'b0, irq_valid}, 0);
    mask[A] = 1'b0;
    step();
    chk("s4_valid", {31'b0, irq_valid}, 1);
    chk("s4_id", 32'(irq_id), 7);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    btn[A] = 1'b0;
    settle(12);

    // B pressed twice without ack -> overflow, then ovf_clr
    btn[B] = 1'b1;
    settle(12);
    chk("s5_id", 32'(irq_id), 8);
    btn[B] = 1'b0;
    settle(12);
    btn[B] = 1'b1;
    settle(12);
    chk("s5_overflow", 32'(overflow), 32'h80);
    chk("s5_pending", 32'(pending), 32'h80);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("s5_ovf_cleared", 32'(overflow), 0);
    chk("s5_pending_kept", 32'(pending), 32'h80);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    btn[B] = 1'b0;
    settle(12);

    // Reset during a presentation discards it
    btn[LEFT] = 1'b1;
    wait_valid(30, n);
    chk("s6_presenting", {31'b0, irq_valid}, 1);
    rst = 1'b1;
    btn = '0;
    step();
    chk("s6_valid", {31'b0, irq_valid}, 0);
    chk("s6_id", 32'(irq_id), 0);
    chk("s6_pending", 32'(pending), 0);
    rst = 1'b0;
    settle(12);

    // Random phase
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(11) == 0) btn[i] = ~btn[i];
      end
      if ($urandom_range(19) == 0) mask = N'($urandom & $urandom);
      irq_ack = ($urandom_range(9) < 3);
      ovf_clr = ($urandom_range(29) == 0);
      rst     = ($urandom_range(499) == 0);
      step();
    end

    // Drain everything still latched
    rst     = 1'b0;
    btn     = '0;
    mask    = '0;
    ovf_clr = 1'b0;
    irq_ack = 1'b1;
    settle(40);
    irq_ack = 1'b0;
    settle(2);
    chk("sb_drained", exp_id_q.size(), 0);
    chk("final_pending", 32'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
